// File: rtl/mem_copy_engine_pkg.sv
// mem_copy_engine_pkg -- width defaults and FSM state encodings shared by the
// copy engine, its interface and the bench. The optional verify-after-write
// path is enabled by defining MEM_COPY_VERIFY_EN.
`ifndef DEFAULT_MADDR_WIDTH
`define DEFAULT_MADDR_WIDTH 16
`endif
`ifndef DEFAULT_MDATA_WIDTH
`define DEFAULT_MDATA_WIDTH 32
`endif

package mem_copy_engine_pkg;

  localparam int STATE_W = 3;

  localparam logic [STATE_W-1:0] ST_IDLE   = 3'd0;
  localparam logic [STATE_W-1:0] ST_READ   = 3'd1;
  localparam logic [STATE_W-1:0] ST_WRITE  = 3'd2;
`ifdef MEM_COPY_VERIFY_EN
  localparam logic [STATE_W-1:0] ST_VERIFY = 3'd3;
`endif
  localparam logic [STATE_W-1:0] ST_DONE   = 3'd4;

endpackage

// File: rtl/mem_copy_engine_if.sv
// mem_copy_engine_if -- command and memory-port bundle for mem_copy_engine.
// Optional macro MEM_COPY_VERIFY_EN only changes the engine's behaviour; the
// signal set is identical in both builds.
//
// Handshake: the engine raises exactly one of mem_read_enable /
// mem_write_enable and holds it, mem_addr and mem_write_data stable until a
// rising clock edge samples the matching ready high; that edge completes the
// transfer (read data is captured on it). Ready while the enable is low is
// ignored. start is only looked at while the engine is idle.
interface mem_copy_engine_if
  import mem_copy_engine_pkg::*;
#(
  parameter int MADDR_WIDTH = `DEFAULT_MADDR_WIDTH,
  parameter int MDATA_WIDTH = `DEFAULT_MDATA_WIDTH
);
  logic                   start;
  logic [MADDR_WIDTH-1:0] src_addr;
  logic [MADDR_WIDTH-1:0] dst_addr;
  logic [MADDR_WIDTH-1:0] length;
  logic                   busy;
  logic                   done;
  logic                   error;
  logic                   mem_read_enable;
  logic                   mem_write_enable;
  logic                   mem_read_ready;
  logic                   mem_write_ready;
  logic [MADDR_WIDTH-1:0] mem_addr;
  logic [MDATA_WIDTH-1:0] mem_write_data;
  logic [MDATA_WIDTH-1:0] mem_read_data;
  logic [STATE_W-1:0]     dbg_state;

  modport master (
    input  start, src_addr, dst_addr, length,
    input  mem_read_ready, mem_write_ready, mem_read_data,
    output busy, done, error, mem_read_enable, mem_write_enable,
    output mem_addr, mem_write_data, dbg_state
  );

  modport slave (
    output start, src_addr, dst_addr, length,
    output mem_read_ready, mem_write_ready, mem_read_data,
    input  busy, done, error, mem_read_enable, mem_write_enable,
    input  mem_addr, mem_write_data, dbg_state
  );
endinterface

// File: rtl/mem_copy_engine.sv
// mem_copy_engine -- word-at-a-time memory copy: read a source word, write it
// to the destination, step both addresses, repeat until the count runs out.
// Define MEM_COPY_VERIFY_EN to re-read each destination word after writing it
// and raise a sticky error on mismatch; otherwise error is tied low.
// The module parameters must match those of the connected interface.
module mem_copy_engine
  import mem_copy_engine_pkg::*;
#(
  parameter int MADDR_WIDTH = `DEFAULT_MADDR_WIDTH,
  parameter int MDATA_WIDTH = `DEFAULT_MDATA_WIDTH
) (
  input  logic              clock,
  input  logic              reset,
  mem_copy_engine_if.master bus
);

  // Byte stride between consecutive words; addition wraps naturally.
  localparam logic [MADDR_WIDTH-1:0] STEP = MADDR_WIDTH'(MDATA_WIDTH / 8);

  logic [STATE_W-1:0]     state_q, state_d;
  logic [MADDR_WIDTH-1:0] src_q, src_d;
  logic [MADDR_WIDTH-1:0] dst_q, dst_d;
  logic [MADDR_WIDTH-1:0] rem_q, rem_d;
  logic [MADDR_WIDTH-1:0] addr_q, addr_d;
  logic [MDATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   rd_en_q, rd_en_d;
  logic                   wr_en_q, wr_en_d;
`ifdef MEM_COPY_VERIFY_EN
  logic                   err_q, err_d;
`endif

  logic                   advance;
  logic [MADDR_WIDTH-1:0] src_nx, dst_nx, rem_nx;

  assign src_nx = src_q + STEP;
  assign dst_nx = dst_q + STEP;
  assign rem_nx = rem_q - MADDR_WIDTH'(1);

  // Next-state logic for the copy sequencer; every output is a register.
  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    dst_d   = dst_q;
    rem_d   = rem_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    rd_en_d = rd_en_q;
    wr_en_d = wr_en_q;
    advance = 1'b0;
`ifdef MEM_COPY_VERIFY_EN
    err_d   = err_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          src_d  = bus.src_addr;
          dst_d  = bus.dst_addr;
          rem_d  = bus.length;
          busy_d = 1'b1;
`ifdef MEM_COPY_VERIFY_EN
          err_d  = 1'b0;
`endif
          if (bus.length == '0) begin
            // Empty copy: one busy cycle, then the done pulse from ST_DONE.
            state_d = ST_DONE;
          end else begin
            state_d = ST_READ;
            rd_en_d = 1'b1;
            addr_d  = bus.src_addr;
          end
        end
      end
      ST_READ: begin
        if (bus.mem_read_ready) begin
          wdata_d = bus.mem_read_data;
          rd_en_d = 1'b0;
          wr_en_d = 1'b1;
          addr_d  = dst_q;
          state_d = ST_WRITE;
        end
      end
      ST_WRITE: begin
        if (bus.mem_write_ready) begin
          wr_en_d = 1'b0;
`ifdef MEM_COPY_VERIFY_EN
          rd_en_d = 1'b1;
          addr_d  = dst_q;
          state_d = ST_VERIFY;
`else
          advance = 1'b1;
`endif
        end
      end
`ifdef MEM_COPY_VERIFY_EN
      ST_VERIFY: begin
        if (bus.mem_read_ready) begin
          rd_en_d = 1'b0;
          if (bus.mem_read_data != wdata_q) begin
            err_d = 1'b1;
          end
          advance = 1'b1;
        end
      end
`endif
      ST_DONE: begin
        // Arrival with done already high came from the last word; arrival
        // with done low came from an empty copy and still owes the pulse.
        if (done_q) begin
          state_d = ST_IDLE;
        end else begin
          done_d = 1'b1;
          busy_d = 1'b0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
        rd_en_d = 1'b0;
        wr_en_d = 1'b0;
      end
    endcase
    if (advance) begin
      src_d = src_nx;
      dst_d = dst_nx;
      rem_d = rem_nx;
      if (rem_nx != '0) begin
        state_d = ST_READ;
        rd_en_d = 1'b1;
        addr_d  = src_nx;
      end else begin
        state_d = ST_DONE;
        busy_d  = 1'b0;
        done_d  = 1'b1;
      end
    end
  end

  // State and output registers; reset abandons any copy immediately.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      rem_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      rd_en_q <= 1'b0;
      wr_en_q <= 1'b0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      rem_q   <= rem_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      rd_en_q <= rd_en_d;
      wr_en_q <= wr_en_d;
    end
  end

`ifdef MEM_COPY_VERIFY_EN
  // Sticky verify-mismatch flag, cleared only by an accepted start.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end
  assign bus.error = err_q;
`else
  assign bus.error = 1'b0;
`endif

  assign bus.busy             = busy_q;
  assign bus.done             = done_q;
  assign bus.mem_read_enable  = rd_en_q;
  assign bus.mem_write_enable = wr_en_q;
  assign bus.mem_addr         = addr_q;
  assign bus.mem_write_data   = wdata_q;
  assign bus.dbg_state        = state_q;

endmodule

// File: doc/mem_copy_engine.md
MEM_COPY_ENGINE -- requirements
Module: mem_copy_engine

Interface
REQ-001 Parameter MADDR_WIDTH, default `DEFAULT_MADDR_WIDTH, memory address width in bits.
REQ-002 Parameter MDATA_WIDTH, default `DEFAULT_MDATA_WIDTH, memory data width in bits (multiple of 8).
REQ-003 Port clock  input  1  single clock; all state on posedge.
REQ-004 Port reset  input  1  asynchronous, active-high reset.
REQ-005 Port start  input  1  request a copy; sampled only in IDLE.
REQ-006 Port src_addr, dst_addr  input  MADDR_WIDTH  first byte address of source and destination.
REQ-007 Port length  input  MADDR_WIDTH  word count to copy.
REQ-008 Port busy  output  1  high while a copy is in progress.
REQ-009 Port done  output  1  one-cycle completion pulse.
REQ-010 Port error  output  1  sticky verify-mismatch flag (VERIFY build only; otherwise tied 0).
REQ-011 Ports mem_read_enable, mem_write_enable  output  1 each  memory requests.
REQ-012 Ports mem_read_ready, mem_write_ready  input  1 each  memory acknowledges.
REQ-013 Ports mem_addr  output  MADDR_WIDTH; mem_write_data  output  MDATA_WIDTH; mem_read_data  input  MDATA_WIDTH.

Function
REQ-014 FSM states: IDLE, READ, WRITE, VERIFY (macro only), DONE; all outputs registered.
REQ-015 IDLE + start=1 at posedge: latch src, dst and length into working registers; busy=1; go to READ with mem_read_enable=1, mem_addr=src, from that edge.
REQ-016 READ: hold mem_read_enable and mem_addr stable until a posedge samples mem_read_ready=1; at that edge capture mem_read_data, drop mem_read_enable, go to WRITE with mem_write_enable=1, mem_addr=dst, mem_write_data=captured word.
REQ-017 WRITE: hold enable, address and data stable until mem_write_ready=1 is sampled; then advance src and dst by MDATA_WIDTH/8, decrement remaining count, and go to READ if remaining>0, else DONE.
REQ-018 mem_read_enable and mem_write_enable are never high in the same cycle.
REQ-019 Zero-wait memory (ready high in the first request cycle): 2 cycles per word, 3 with VERIFY.
REQ-020 DONE: done=1, busy=0 for exactly one cycle, then IDLE; a start in the DONE cycle is ignored.
REQ-021 length=0: start goes straight to DONE (busy high one cycle, no memory access, done on the following cycle).
REQ-022 start while busy is ignored; input changes while busy have no effect.
REQ-023 Address increments wrap modulo 2^MADDR_WIDTH.
REQ-024 Copies run forward only; overlapping regions with dst>src are not protected.

Reset
REQ-025 Reset asserted forces IDLE immediately, without waiting for a clock edge; outputs reset to: busy=0, done=0, error=0, both enables=0, mem_addr=0, mem_write_data=0.
REQ-026 Reset mid-transfer abandons the copy; no further memory requests issue and no done pulse follows.

Configuration
REQ-027 Macro MEM_COPY_VERIFY_EN defined: after each write ack, enter VERIFY, re-read dst, and compare against the written word; a mismatch sets error, which stays set until the next accepted start; the copy continues.
REQ-028 Macro undefined: the VERIFY state and comparator are absent, error is constant 0, and WRITE proceeds directly per REQ-017.

Structure
REQ-029 Width defaults and FSM state encodings are defined in the shared constants header; no other typedefs are needed.
REQ-030 Implementation is a single module with no sub-module; the handshake and sequencing are one FSM.

Verification
REQ-031 Bench uses MDATA_WIDTH=32 and a block-RAM model with a random 0-3 cycle ready delay.
REQ-032 Preload 0x10..0x1C with 4 random words; start with src=0x10, dst=0x40, len=4 -> 0x40..0x4C match the source words, done pulses once, busy falls with done.
REQ-033 len=0 -> done 2 cycles after start; no enable is ever asserted.
REQ-034 src=2^MADDR_WIDTH-4, len=2 -> the second read is at address 0 (wrap).
REQ-035 Reset asserted during the 2nd WRITE of a len=8 copy -> enables drop at once, only 1-2 destination words change, and no done pulse.
REQ-036 With MEM_COPY_VERIFY_EN, the model corrupts the write to 0x44 -> error=1 after the copy, all 4 words are processed, and error clears on the next start.
